vscale_mem_arbiter: RTL and testbench
=====================================

Name: vscale_mem_arbiter

Overview:
Shares one single-outstanding memory bus between the core's instruction port (imem) and data port (dmem).
- Grants one requester at a time and latches its command.
- Issues the command with a valid/ready handshake and waits for the response.
- Returns read data, wait and badmem_e to the granted requester; badmem_e covers misalignment, bus error and timeout.
- Sits between the vscale pipeline (imem_wait/dmem_wait and imem_badmem_e/dmem_badmem_e consumers) and the memory/bridge.

Parameters:
ADDR_WIDTH, 32, address width of both ports and the bus
DATA_WIDTH, 32, data width of both ports and the bus
TIMEOUT_CYCLES, 255, maximum cycles spent in S_RESP before forced error completion (at least 1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
imem_en  in  1  instruction fetch request; held, with imem_addr stable, while imem_wait=1
imem_addr  in  ADDR_WIDTH  fetch address (word size implied)
imem_rdata  out  DATA_WIDTH  fetch data, valid when imem_en && !imem_wait
imem_wait  out  1  fetch not yet complete
imem_badmem_e  out  1  fetch completed with error (single-cycle, with !imem_wait)
dmem_en  in  1  data request; held stable while dmem_wait=1
dmem_wen  in  1  1=store, 0=load
dmem_size  in  3  funct3 size code (0 B, 1 H, 2 W, 4 BU, 5 HU)
dmem_addr  in  ADDR_WIDTH  data address
dmem_wdata  in  DATA_WIDTH  store data
dmem_rdata  out  DATA_WIDTH  load data, valid when dmem_en && !dmem_wait
dmem_wait  out  1  data access not yet complete
dmem_badmem_e  out  1  data access completed with error
mem_req_valid  out  1  bus command valid
mem_req_ready  in  1  bus accepts command
mem_addr  out  ADDR_WIDTH  latched address
mem_wen  out  1  latched write enable
mem_size  out  3  latched size (imem: 2)
mem_wdata  out  DATA_WIDTH  latched store data
mem_resp_valid  in  1  response valid (one cycle)
mem_resp_err  in  1  response error, qualified by mem_resp_valid
mem_rdata  in  DATA_WIDTH  response data

Behaviour:
- Reset: state=S_IDLE; all mem_* outputs 0; last_grant=IMEM; timeout counter 0.
- While reset_n=0: both wait outputs are 1 if the port's en is 1; badmem_e outputs 0.
- States:
  - S_IDLE: choose a winner among requesters with en=1 and run the alignment check.
    - Misaligned or illegal size (size[1:0]=3, H with addr[0]=1, W with addr[1:0]!=0): winner gets wait=0 and badmem_e=1 this cycle, no bus access, stay in S_IDLE.
    - Otherwise latch the command (addr, wen, size, wdata; imem forces wen=0, size=2) and go to S_REQ.
  - S_REQ: mem_req_valid=1 (registered). On mem_req_ready go to S_RESP and clear the counter.
  - S_RESP: the counter increments each cycle.
    - On mem_resp_valid: winner wait=0, rdata=mem_rdata (combinational pass-through), badmem_e=mem_resp_err; go to S_IDLE.
    - Else if counter==TIMEOUT_CYCLES-1: complete with badmem_e=1 and rdata=0; go to S_IDLE.
- Minimum latency: request seen in cycle N, completion in cycle N+2 (mem_req_ready and mem_resp_valid both immediate).
- wait for a port = en && !(port is winner && completing this cycle). A non-granted requesting port always sees wait=1.
- mem_resp_valid outside S_RESP is ignored; the stale response after a timeout is dropped.
- A new request may be granted in the cycle after completion (back-to-back).
- Arbitration, default: dmem has fixed priority over imem.
- Requester dropping en mid-transaction (illegal): the transaction still completes on the bus and the result is discarded.
- reset_n asserted mid-transaction: immediate return to S_IDLE, mem_req_valid drops; the bus must tolerate abandonment.

Optional Feature:
VSCALE_ARB_RR_EN
- Defined: round-robin arbitration. When both request in S_IDLE, the port not equal to last_grant wins; last_grant updates on every grant, including alignment-error completions.
- Undefined: fixed dmem priority; last_grant register is absent.

Decomposition:
- Shared header vscale_arb_constants.vh: state encodings S_IDLE/S_REQ/S_RESP, grant IDs GNT_IMEM/GNT_DMEM, size code constants.
- Size codes reuse the existing funct3 definitions in rv32_opcodes.vh where present.
- One sub-module, vscale_arb_align_check: purely combinational (addr[1:0], size) -> misaligned.

Test Plan:
- dmem load addr 0x100, size 2, ready immediate, resp next cycle with 0xDEADBEEF -> dmem_wait 1,1,0; dmem_rdata=0xDEADBEEF at completion; mem_size=2, mem_wen=0.
- imem and dmem both request at 0x0/0x40 -> dmem granted first; imem_wait stays 1 until the second transaction; RR_EN build: a second simultaneous pair grants imem first.
- dmem store size 1, addr 0x3 -> same-cycle dmem_wait=0, dmem_badmem_e=1; mem_req_valid never asserted.
- mem_req_ready held 0 for 5 cycles, then resp with mem_resp_err=1 -> mem_req_valid high for 6 cycles; badmem_e pulses once at completion.
- TIMEOUT_CYCLES=4, no response -> completion with badmem_e=1 on the 4th S_RESP cycle; a late mem_resp_valid in S_IDLE produces no output change.
- reset_n pulsed low during S_RESP -> state S_IDLE, mem_req_valid=0; a held request is re-granted after release.

Source files
------------

// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared definitions for the vscale memory arbiter.
// Contents:
//   state_t - arbiter FSM states (S_IDLE, S_REQ, S_RESP)
//   gnt_t   - grant identifiers (GNT_IMEM, GNT_DMEM)
//   SIZE_*  - funct3 access size codes, plus the two-bit width classes
//             that the alignment check decodes
package vscale_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } gnt_t;

  // funct3 load/store size codes
  localparam logic [2:0] SIZE_B  = 3'd0;
  localparam logic [2:0] SIZE_H  = 3'd1;
  localparam logic [2:0] SIZE_W  = 3'd2;
  localparam logic [2:0] SIZE_BU = 3'd4;
  localparam logic [2:0] SIZE_HU = 3'd5;

  // Width class carried in size[1:0]; the sign bit size[2] does not affect alignment
  localparam logic [1:0] SIZE_LO_B   = 2'd0;
  localparam logic [1:0] SIZE_LO_H   = 2'd1;
  localparam logic [1:0] SIZE_LO_W   = 2'd2;
  localparam logic [1:0] SIZE_LO_BAD = 2'd3;

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// Single-outstanding memory bus between the arbiter and the memory/bridge.
// Signals:
//   mem_req_valid/mem_req_ready - command handshake
//   mem_addr/mem_wen/mem_size/mem_wdata - latched command
//   mem_resp_valid/mem_resp_err/mem_rdata - one-cycle response
// Modports: master (arbiter side), slave (memory side).
interface vscale_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [2:0]            mem_size;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_resp_valid;
  logic                  mem_resp_err;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req_valid,
    input  mem_req_ready,
    output mem_addr,
    output mem_wen,
    output mem_size,
    output mem_wdata,
    input  mem_resp_valid,
    input  mem_resp_err,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid,
    output mem_req_ready,
    input  mem_addr,
    input  mem_wen,
    input  mem_size,
    input  mem_wdata,
    output mem_resp_valid,
    output mem_resp_err,
    output mem_rdata
  );

endinterface

// File: rtl/vscale_arb_align_check.sv
// Combinational alignment check for a memory access.
// Ports:
//   addr_lo    in  2  low address bits
//   size_lo    in  2  width class of the funct3 size (size[1:0])
//   misaligned out 1  access is misaligned or the size is illegal
module vscale_arb_align_check
  import vscale_mem_arbiter_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size_lo)
      SIZE_LO_B:   misaligned = 1'b0;
      SIZE_LO_H:   misaligned = addr_lo[0];
      SIZE_LO_W:   misaligned = (addr_lo != 2'b00);
      SIZE_LO_BAD: misaligned = 1'b1;
      default:     misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Arbitrates one single-outstanding memory bus between the vscale
// instruction port (imem) and data port (dmem).
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   imem_en/imem_addr             fetch request (held while imem_wait)
//   imem_rdata/wait/badmem_e      fetch result
//   dmem_en/wen/size/addr/wdata   data request (held while dmem_wait)
//   dmem_rdata/wait/badmem_e      data result
//   mem                           bus master modport (vscale_mem_arbiter_if)
// Build option:
//   VSCALE_ARB_RR_EN - round-robin arbitration when both ports request;
//                      otherwise dmem has fixed priority.
module vscale_mem_arbiter
  import vscale_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  imem_en,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_wait,
  output logic                  imem_badmem_e,
  input  logic                  dmem_en,
  input  logic                  dmem_wen,
  input  logic [2:0]            dmem_size,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_wait,
  output logic                  dmem_badmem_e,
  vscale_mem_arbiter_if.master  mem
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  gnt_t                  gnt_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  any_req;
  logic                  win_dmem;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_wen;
  logic [2:0]            sel_size;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  misaligned;

  logic                  grant_load;
  logic                  complete;
  logic                  done_ok;
  gnt_t                  done_gnt;
  logic                  done_err;
  logic [DATA_WIDTH-1:0] done_data;

`ifdef VSCALE_ARB_RR_EN
  gnt_t last_grant_q;
  logic grant_evt;
`endif

  // Winner selection among current requesters
  always_comb begin
    any_req = imem_en || dmem_en;
`ifdef VSCALE_ARB_RR_EN
    win_dmem = dmem_en && (!imem_en || (last_grant_q == GNT_IMEM));
`else
    win_dmem = dmem_en;
`endif
    // imem accesses are always word loads
    sel_addr  = win_dmem ? dmem_addr  : imem_addr;
    sel_wen   = win_dmem ? dmem_wen   : 1'b0;
    sel_size  = win_dmem ? dmem_size  : SIZE_W;
    sel_wdata = win_dmem ? dmem_wdata : '0;
  end

  vscale_arb_align_check u_align (
    .addr_lo    (sel_addr[1:0]),
    .size_lo    (sel_size[1:0]),
    .misaligned (misaligned)
  );

  // Next-state, completion and grant decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_load = 1'b0;
    complete   = 1'b0;
    done_gnt   = gnt_q;
    done_err   = 1'b0;
    done_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          done_gnt = win_dmem ? GNT_DMEM : GNT_IMEM;
          if (misaligned) begin
            // Alignment errors complete in place without touching the bus
            complete = 1'b1;
            done_err = 1'b1;
          end else begin
            grant_load = 1'b1;
            state_d    = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem.mem_req_ready) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem.mem_resp_valid) begin
          complete  = 1'b1;
          done_err  = mem.mem_resp_err;
          done_data = mem.mem_rdata;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          complete = 1'b1;
          done_err = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // While in reset nothing completes; requesters just see wait
  assign done_ok = complete && reset_n;

  always_comb begin
    imem_wait     = imem_en && !(done_ok && (done_gnt == GNT_IMEM));
    dmem_wait     = dmem_en && !(done_ok && (done_gnt == GNT_DMEM));
    imem_badmem_e = imem_en && done_ok && (done_gnt == GNT_IMEM) && done_err;
    dmem_badmem_e = dmem_en && done_ok && (done_gnt == GNT_DMEM) && done_err;
    imem_rdata    = (done_ok && (done_gnt == GNT_IMEM)) ? done_data : '0;
    dmem_rdata    = (done_ok && (done_gnt == GNT_DMEM)) ? done_data : '0;
  end

  // State, grant, timeout counter and latched command
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= GNT_IMEM;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_load) begin
        gnt_q       <= done_gnt;
        req_valid_q <= 1'b1;
        addr_q      <= sel_addr;
        wen_q       <= sel_wen;
        size_q      <= sel_size;
        wdata_q     <= sel_wdata;
      end else if ((state_q == S_REQ) && mem.mem_req_ready) begin
        req_valid_q <= 1'b0;
      end
    end
  end

`ifdef VSCALE_ARB_RR_EN
  // Every grant counts, including alignment-error completions
  assign grant_evt = (state_q == S_IDLE) && any_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GNT_IMEM;
    end else if (grant_evt) begin
      last_grant_q <= done_gnt;
    end
  end
`endif

  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wen       = wen_q;
  assign mem.mem_size      = size_q;
  assign mem.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
module tb_vscale_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_wait;
  logic        imem_badmem_e;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  vscale_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

  vscale_mem_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_wait     (imem_wait),
    .imem_badmem_e (imem_badmem_e),
    .dmem_en       (dmem_en),
    .dmem_wen      (dmem_wen),
    .dmem_size     (dmem_size),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_wait     (dmem_wait),
    .dmem_badmem_e (dmem_badmem_e),
    .mem           (mem_bus.master)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t iq[$];
  exp_t dq[$];
  bit   tb_last_d = 1'b0;   // expected last grant: 1 = dmem

  // memory model configuration
  int          cfg_ready_delay = 0;
  int          cfg_resp_delay  = 0;
  logic        cfg_err         = 1'b0;
  logic [31:0] cfg_salt        = 32'h5A5A_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ready after cfg_ready_delay valid cycles, response
  // cfg_resp_delay cycles after the handshake, data = addr ^ cfg_salt.
  initial begin : mem_model
    bit          hs;
    bit          pending;
    int          rdy_cnt;
    int          resp_cnt;
    logic [31:0] p_data;
    logic        p_err;
    pending = 1'b0; rdy_cnt = 0; resp_cnt = 0; p_data = '0; p_err = 1'b0;
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_err   = 1'b0;
    mem_bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      hs = mem_bus.mem_req_valid && mem_bus.mem_req_ready;
      if (hs) begin
        p_data = mem_bus.mem_addr ^ cfg_salt;
        p_err  = cfg_err;
      end
      if (!reset_n) begin
        hs = 1'b0;
        pending = 1'b0;
      end
      @(posedge clk);
      #1;
      if (mem_bus.mem_req_valid) begin
        mem_bus.mem_req_ready = (rdy_cnt >= cfg_ready_delay);
        if (rdy_cnt < cfg_ready_delay) rdy_cnt++;
      end else begin
        mem_bus.mem_req_ready = 1'b0;
        rdy_cnt = 0;
      end
      mem_bus.mem_resp_valid = 1'b0;
      mem_bus.mem_resp_err   = 1'b0;
      mem_bus.mem_rdata      = '0;
      if (hs) begin
        pending  = 1'b1;
        resp_cnt = 0;
      end
      if (pending) begin
        if (resp_cnt >= cfg_resp_delay) begin
          mem_bus.mem_resp_valid = 1'b1;
          mem_bus.mem_resp_err   = p_err;
          mem_bus.mem_rdata      = p_data;
          pending = 1'b0;
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard: every completion seen on a port pops that port's queue
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (dmem_en && !dmem_wait) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL dmem_unexpected_completion: rdata=%h badmem=%b with no pending request", dmem_rdata, dmem_badmem_e);
          end else begin
            e = dq.pop_front();
            if (dmem_rdata !== e.data || dmem_badmem_e !== e.err) begin
              errors++;
              $display("FAIL dmem_result: got rdata=%h badmem=%b expected rdata=%h badmem=%b", dmem_rdata, dmem_badmem_e, e.data, e.err);
            end
          end
        end
        if (imem_en && !imem_wait) begin
          checks++;
          if (iq.size() == 0) begin
            errors++;
            $display("FAIL imem_unexpected_completion: rdata=%h badmem=%b with no pending request", imem_rdata, imem_badmem_e);
          end else begin
            e = iq.pop_front();
            if (imem_rdata !== e.data || imem_badmem_e !== e.err) begin
              errors++;
              $display("FAIL imem_result: got rdata=%h badmem=%b expected rdata=%h badmem=%b", imem_rdata, imem_badmem_e, e.data, e.err);
            end
          end
        end
      end
    end
  endtask

  // Drives one request (called just after a posedge), runs until the port
  // completes and releases en; reports timing and the command seen on the bus.
  task automatic run_single(input bit is_d, input logic wen, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int done_at, output int vld_cnt, output int bad_cnt,
                            output logic [31:0] b_addr, output logic b_wen,
                            output logic [2:0] b_size, output logic [31:0] b_wdata);
    bit done;
    done = 1'b0; done_at = -1; vld_cnt = 0; bad_cnt = 0;
    b_addr = 'x; b_wen = 1'bx; b_size = 'x; b_wdata = 'x;
    if (is_d) begin
      dmem_en = 1'b1; dmem_wen = wen; dmem_size = size; dmem_addr = addr; dmem_wdata = wdata;
    end else begin
      imem_en = 1'b1; imem_addr = addr;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_bus.mem_req_valid) begin
        if (vld_cnt == 0) begin
          b_addr = mem_bus.mem_addr; b_wen = mem_bus.mem_wen;
          b_size = mem_bus.mem_size; b_wdata = mem_bus.mem_wdata;
        end
        vld_cnt++;
      end
      bad_cnt += is_d ? int'(dmem_badmem_e) : int'(imem_badmem_e);
      if (is_d ? (dmem_en && !dmem_wait) : (imem_en && !imem_wait)) begin
        done = 1'b1;
        done_at = c;
      end
      @(posedge clk);
      #1;
    end
    if (is_d) dmem_en = 1'b0; else imem_en = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_bound: request at addr %h never completed within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    imem_en = 1'b1; imem_addr = 32'h0;
    dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'd1; dmem_addr = 32'h3; dmem_wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_wait !== 1'b1 || dmem_wait !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: imem_wait=%b dmem_wait=%b expected 1 1", imem_wait, dmem_wait);
    end
    checks++;
    if (imem_badmem_e !== 1'b0 || dmem_badmem_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_badmem: imem=%b dmem=%b expected 0 0", imem_badmem_e, dmem_badmem_e);
    end
    checks++;
    if (mem_bus.mem_req_valid !== 1'b0 || mem_bus.mem_addr !== 32'h0 || mem_bus.mem_wen !== 1'b0 ||
        mem_bus.mem_size !== 3'd0 || mem_bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: valid=%b addr=%h wen=%b size=%0d wdata=%h expected all zero",
               mem_bus.mem_req_valid, mem_bus.mem_addr, mem_bus.mem_wen, mem_bus.mem_size, mem_bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    imem_en = 1'b0; dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd2;
    reset_n = 1'b1;
    tb_last_d = 1'b0;
  endtask

  task automatic test_dmem_load();
    cfg_salt = 32'hDEADBEEF ^ 32'h100;
    dq.push_back('{32'hDEADBEEF, 1'b0});
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h100; dmem_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (dmem_wait !== (c < 2)) begin
        errors++;
        $display("FAIL load_wait_c%0d: dmem_wait=%b expected %b", c, dmem_wait, (c < 2));
      end
      if (c == 1) begin
        checks++;
        if (mem_bus.mem_req_valid !== 1'b1 || mem_bus.mem_addr !== 32'h100 ||
            mem_bus.mem_size !== 3'd2 || mem_bus.mem_wen !== 1'b0) begin
          errors++;
          $display("FAIL load_cmd: valid=%b addr=%h size=%0d wen=%b expected 1 00000100 2 0",
                   mem_bus.mem_req_valid, mem_bus.mem_addr, mem_bus.mem_size, mem_bus.mem_wen);
        end
      end
      @(posedge clk);
      #1;
    end
    dmem_en = 1'b0;
    tb_last_d = 1'b1;
    cfg_salt = 32'h5A5A_0000;
  endtask

  task automatic test_arbitration();
    bit d_first;
    int i_done, d_done, first_done, second_done;
    for (int p = 0; p < 2; p++) begin
`ifdef VSCALE_ARB_RR_EN
      d_first = !tb_last_d;
`else
      d_first = 1'b1;
`endif
      i_done = -1; d_done = -1;
      iq.push_back('{32'h0 ^ cfg_salt, 1'b0});
      dq.push_back('{32'h40 ^ cfg_salt, 1'b0});
      imem_en = 1'b1; imem_addr = 32'h0;
      dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h40;
      for (int c = 0; c < 20 && (i_done < 0 || d_done < 0); c++) begin
        @(negedge clk);
        if (imem_en && !imem_wait) i_done = c;
        if (dmem_en && !dmem_wait) d_done = c;
        @(posedge clk);
        #1;
        if (i_done >= 0) imem_en = 1'b0;
        if (d_done >= 0) dmem_en = 1'b0;
      end
      imem_en = 1'b0; dmem_en = 1'b0;
      first_done  = d_first ? d_done : i_done;
      second_done = d_first ? i_done : d_done;
      checks++;
      if (first_done !== 2) begin
        errors++;
        $display("FAIL arb_first_p%0d: first port (dmem=%b) completed at cycle %0d expected 2", p, d_first, first_done);
      end
      checks++;
      if (second_done !== 5) begin
        errors++;
        $display("FAIL arb_second_p%0d: second port completed at cycle %0d expected 5", p, second_done);
      end
      tb_last_d = !d_first;
    end
  endtask

  task automatic test_misaligned();
    bit          t_d[3]    = '{1'b1, 1'b0, 1'b1};
    logic        t_wen[3]  = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  t_size[3] = '{3'd1, 3'd2, 3'd3};
    logic [31:0] t_addr[3] = '{32'h3, 32'h2, 32'h0};
    int done_at, vld_cnt, bad_cnt;
    logic [31:0] ba, bw; logic bwen; logic [2:0] bs;
    for (int k = 0; k < 3; k++) begin
      if (t_d[k]) dq.push_back('{32'h0, 1'b1}); else iq.push_back('{32'h0, 1'b1});
      run_single(t_d[k], t_wen[k], t_size[k], t_addr[k], 32'h1234, done_at, vld_cnt, bad_cnt, ba, bwen, bs, bw);
      checks++;
      if (done_at !== 0 || vld_cnt !== 0 || bad_cnt !== 1) begin
        errors++;
        $display("FAIL misalign_%0d: done_at=%0d req_valid_cycles=%0d badmem_cycles=%0d expected 0 0 1", k, done_at, vld_cnt, bad_cnt);
      end
      @(negedge clk);
      checks++;
      if (mem_bus.mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL misalign_%0d_bus: mem_req_valid=%b expected 0", k, mem_bus.mem_req_valid);
      end
      @(posedge clk);
      #1;
      tb_last_d = t_d[k];
    end
  endtask

  task automatic test_store_byte();
    int done_at, vld_cnt, bad_cnt;
    logic [31:0] ba, bw; logic bwen; logic [2:0] bs;
    dq.push_back('{32'h103 ^ cfg_salt, 1'b0});
    run_single(1'b1, 1'b1, 3'd0, 32'h103, 32'hA5, done_at, vld_cnt, bad_cnt, ba, bwen, bs, bw);
    tb_last_d = 1'b1;
    checks++;
    if (done_at !== 2 || vld_cnt !== 1) begin
      errors++;
      $display("FAIL store_timing: done_at=%0d req_valid_cycles=%0d expected 2 1", done_at, vld_cnt);
    end
    checks++;
    if (ba !== 32'h103 || bwen !== 1'b1 || bs !== 3'd0 || bw !== 32'hA5) begin
      errors++;
      $display("FAIL store_cmd: addr=%h wen=%b size=%0d wdata=%h expected 00000103 1 0 000000a5", ba, bwen, bs, bw);
    end
  endtask

  task automatic test_ready_stall();
    int done_at, vld_cnt, bad_cnt;
    logic [31:0] ba, bw; logic bwen; logic [2:0] bs;
    cfg_ready_delay = 5; cfg_err = 1'b1;
    dq.push_back('{32'h200 ^ cfg_salt, 1'b1});
    run_single(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, done_at, vld_cnt, bad_cnt, ba, bwen, bs, bw);
    tb_last_d = 1'b1;
    checks++;
    if (vld_cnt !== 6) begin
      errors++;
      $display("FAIL stall_valid: mem_req_valid high %0d cycles expected 6", vld_cnt);
    end
    checks++;
    if (done_at !== 7 || bad_cnt !== 1) begin
      errors++;
      $display("FAIL stall_done: done_at=%0d badmem_cycles=%0d expected 7 1", done_at, bad_cnt);
    end
    cfg_ready_delay = 0; cfg_err = 1'b0;
  endtask

  task automatic test_timeout();
    int done_at, vld_cnt, bad_cnt;
    logic [31:0] ba, bw; logic bwen; logic [2:0] bs;
    cfg_resp_delay = 6;
    // leave dmem_wen/size at a store-byte setting to show imem forces its own
    dmem_wen = 1'b1; dmem_size = 3'd0;
    iq.push_back('{32'h0, 1'b1});
    run_single(1'b0, 1'b0, 3'd2, 32'h80, 32'h0, done_at, vld_cnt, bad_cnt, ba, bwen, bs, bw);
    tb_last_d = 1'b0;
    checks++;
    if (done_at !== 5 || bad_cnt !== 1) begin
      errors++;
      $display("FAIL timeout_done: done_at=%0d badmem_cycles=%0d expected 5 1", done_at, bad_cnt);
    end
    checks++;
    if (ba !== 32'h80 || bwen !== 1'b0 || bs !== 3'd2) begin
      errors++;
      $display("FAIL imem_cmd: addr=%h wen=%b size=%0d expected 00000080 0 2", ba, bwen, bs);
    end
    // stale response lands while idle
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (imem_badmem_e !== 1'b0 || dmem_badmem_e !== 1'b0 || imem_rdata !== 32'h0 ||
          dmem_rdata !== 32'h0 || mem_bus.mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_resp_c%0d: ibad=%b dbad=%b irdata=%h drdata=%h valid=%b expected all zero",
                 c, imem_badmem_e, dmem_badmem_e, imem_rdata, dmem_rdata, mem_bus.mem_req_valid);
      end
      @(posedge clk);
      #1;
    end
    cfg_resp_delay = 0;
  endtask

  task automatic test_back_to_back();
    bit          t_d[3]    = '{1'b1, 1'b1, 1'b0};
    logic [31:0] t_addr[3] = '{32'h300, 32'h304, 32'h308};
    int done_at, vld_cnt, bad_cnt;
    logic [31:0] ba, bw; logic bwen; logic [2:0] bs;
    for (int k = 0; k < 3; k++) begin
      if (t_d[k]) dq.push_back('{t_addr[k] ^ cfg_salt, 1'b0});
      else        iq.push_back('{t_addr[k] ^ cfg_salt, 1'b0});
      run_single(t_d[k], 1'b0, 3'd2, t_addr[k], 32'h0, done_at, vld_cnt, bad_cnt, ba, bwen, bs, bw);
      tb_last_d = t_d[k];
      checks++;
      if (done_at !== 2 || ba !== t_addr[k]) begin
        errors++;
        $display("FAIL b2b_%0d: done_at=%0d bus_addr=%h expected 2 %h", k, done_at, ba, t_addr[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_at;
    cfg_resp_delay = 50;
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h400;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_bus.mem_req_valid !== 1'b0 || mem_bus.mem_addr !== 32'h0 ||
        dmem_wait !== 1'b1 || dmem_badmem_e !== 1'b0) begin
      errors++;
      $display("FAIL midreset: valid=%b addr=%h dmem_wait=%b badmem=%b expected 0 00000000 1 0",
               mem_bus.mem_req_valid, mem_bus.mem_addr, dmem_wait, dmem_badmem_e);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cfg_resp_delay = 0;
    dq.push_back('{32'h400 ^ cfg_salt, 1'b0});
    done_at = -1;
    for (int c = 0; c < 10 && done_at < 0; c++) begin
      @(negedge clk);
      if (dmem_en && !dmem_wait) done_at = c;
      @(posedge clk);
      #1;
    end
    dmem_en = 1'b0;
    tb_last_d = 1'b1;
    checks++;
    if (done_at !== 2) begin
      errors++;
      $display("FAIL regrant: held request completed at cycle %0d after release expected 2", done_at);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    imem_en = 1'b0; imem_addr = '0;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = '0; dmem_wdata = '0;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_dmem_load();
    test_arbitration();
    test_misaligned();
    test_store_byte();
    test_ready_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (iq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: imem pending %0d dmem pending %0d expected 0 0", iq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
